// File: rtl/alsu_ctrl_pkg.sv
// Shared types, command field layout and helpers for the ALSU arbiter.
package alsu_ctrl_pkg;

    localparam int unsigned CMD_W = 16;
    localparam int unsigned OUT_W = 6;
    localparam int unsigned OPC_W = 3;
    localparam int unsigned OPD_W = 3;

    // Command word bit offsets
    localparam int unsigned OPC_LSB       = 13;
    localparam int unsigned A_LSB         = 10;
    localparam int unsigned B_LSB         = 7;
    localparam int unsigned CIN_BIT       = 6;
    localparam int unsigned SERIAL_IN_BIT = 5;
    localparam int unsigned DIRECTION_BIT = 4;
    localparam int unsigned RED_OP_A_BIT  = 3;
    localparam int unsigned RED_OP_B_BIT  = 2;
    localparam int unsigned BYPASS_A_BIT  = 1;
    localparam int unsigned BYPASS_B_BIT  = 0;

    // ALSU opcodes
    localparam logic [OPC_W-1:0] OP_OR     = 3'd0;
    localparam logic [OPC_W-1:0] OP_XOR    = 3'd1;
    localparam logic [OPC_W-1:0] OP_ADD    = 3'd2;
    localparam logic [OPC_W-1:0] OP_MUL    = 3'd3;
    localparam logic [OPC_W-1:0] OP_SHIFT  = 3'd4;
    localparam logic [OPC_W-1:0] OP_ROTATE = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        CAPT  = 2'd3
    } state_t;

    // Invalid command: reduction on a non-logic op, or an undefined opcode
    function automatic logic cmd_err(input logic [CMD_W-1:0] cmd);
        logic [OPC_W-1:0] op;
        logic             red;
        op  = cmd[OPC_LSB +: OPC_W];
        red = cmd[RED_OP_A_BIT] | cmd[RED_OP_B_BIT];
        return (red & (op[1] | op[2])) | (op[2] & op[1]);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-port arbiter: round-robin or port-0 fixed priority, grants only when enabled.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       mode,
    output logic [1:0] gnt
);

    logic last_owner;

    // Grant selection; a tie goes to port 0 in fixed mode or to the port not served last
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = (mode || last_owner) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Remember which port was served by the most recent grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_owner <= gnt[1];
        end
    end

endmodule

// File: rtl/alsu_arbiter.sv
// Shares one registered ALSU between two command ports, one op every four cycles.
module alsu_arbiter
    import alsu_ctrl_pkg::*;
#(
    parameter string ARB_MODE = "RR"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [CMD_W-1:0] cmd0,
    input  logic [CMD_W-1:0] cmd1,
    output logic [1:0]       gnt,
    output logic [CMD_W-1:0] alsu_cmd,
    input  logic [OUT_W-1:0] alsu_out,
    output logic [1:0]       rsp_valid,
    output logic [OUT_W-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    localparam logic FIXED_MODE = (ARB_MODE == "FIXED0");

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             err_q;
    logic             accept;
    logic             capture;
    logic             arb_en;
    logic [CMD_W-1:0] sel_cmd;

    // Grants are only offered while idle and never while reset is held
    assign arb_en  = (state == IDLE) && !rst;
    assign accept  = (gnt != 2'b00);
    assign sel_cmd = gnt[1] ? cmd1 : cmd0;
    assign busy    = (state != IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .enable (arb_en),
        .mode   (FIXED_MODE),
        .gnt    (gnt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: fixed four-cycle walk once a command is accepted
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        unique case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: state_nxt = EXEC;
            EXEC:  state_nxt = CAPT;
            CAPT: begin
                state_nxt = IDLE;
                capture   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch held stable for the ALSU, and result capture toward the owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alsu_cmd  <= '0;
            owner     <= 1'b0;
            err_q     <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            if (accept) begin
                alsu_cmd <= sel_cmd;
                owner    <= gnt[1];
                err_q    <= cmd_err(sel_cmd);
            end
            if (capture) begin
                rsp_data  <= alsu_out;
                rsp_err   <= err_q;
                rsp_valid <= owner ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter: directed table, reset abort, tie arbitration and random traffic.
module tb_alsu_arbiter;
    import alsu_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] cmd0, cmd1;
    logic [1:0]  gnt;
    logic [15:0] alsu_cmd;
    logic [5:0]  alsu_out;
    logic [1:0]  rsp_valid;
    logic [5:0]  rsp_data;
    logic        rsp_err;
    logic        busy;

    logic [1:0]  req_fx;
    logic [5:0]  alsu_out_fx;
    logic [1:0]  gnt_fx;
    logic [15:0] alsu_cmd_fx;
    logic [1:0]  rsp_valid_fx;
    logic [5:0]  rsp_data_fx;
    logic        rsp_err_fx;
    logic        busy_fx;

    int n_tests = 0;
    int n_fail  = 0;

    alsu_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .cmd0(cmd0), .cmd1(cmd1), .gnt(gnt),
        .alsu_cmd(alsu_cmd), .alsu_out(alsu_out), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    alsu_arbiter #(.ARB_MODE("FIXED0")) dut_fx (
        .clk(clk), .rst(rst), .req(req_fx), .cmd0(cmd0), .cmd1(cmd1), .gnt(gnt_fx),
        .alsu_cmd(alsu_cmd_fx), .alsu_out(alsu_out_fx), .rsp_valid(rsp_valid_fx),
        .rsp_data(rsp_data_fx), .rsp_err(rsp_err_fx), .busy(busy_fx)
    );

    assign req_fx      = 2'b11;
    assign alsu_out_fx = 6'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural invalid-command rule
    function automatic logic ref_err(input logic [15:0] c);
        int op;
        op = int'(c[OPC_LSB +: 3]);
        return ((c[RED_OP_A_BIT] || c[RED_OP_B_BIT]) && op >= 2) || op >= 6;
    endfunction

    // Behavioural ALSU result (A input priority, full adder)
    function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] prev);
        logic signed [2:0] a, b;
        logic [2:0] op;
        int ai, bi, r;
        a  = c[A_LSB +: 3];
        b  = c[B_LSB +: 3];
        ai = int'(a);
        bi = int'(b);
        op = c[OPC_LSB +: 3];
        r  = 0;
        if (c[BYPASS_A_BIT]) r = ai;
        else if (c[BYPASS_B_BIT]) r = bi;
        else if (ref_err(c)) r = 0;
        else if (op == OP_OR) r = c[RED_OP_A_BIT] ? ((|a) ? 1 : 0) : c[RED_OP_B_BIT] ? ((|b) ? 1 : 0) : (ai | bi);
        else if (op == OP_XOR) r = c[RED_OP_A_BIT] ? ((^a) ? 1 : 0) : c[RED_OP_B_BIT] ? ((^b) ? 1 : 0) : (ai ^ bi);
        else if (op == OP_ADD) r = ai + bi + (c[CIN_BIT] ? 1 : 0);
        else if (op == OP_MUL) r = ai * bi;
        else if (op == OP_SHIFT)
            return c[DIRECTION_BIT] ? {prev[4:0], c[SERIAL_IN_BIT]} : {c[SERIAL_IN_BIT], prev[5:1]};
        else if (op == OP_ROTATE)
            return c[DIRECTION_BIT] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
        return 6'(r);
    endfunction

    // Stand-in for the shared ALSU: inputs registered, then output registered
    logic [15:0] alsu_in;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alsu_in  <= '0;
            alsu_out <= '0;
        end else begin
            alsu_in  <= alsu_cmd;
            alsu_out <= alsu_f(alsu_in, alsu_out);
        end
    end

    function automatic logic [15:0] mk_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                           input logic cin, input logic si, input logic dir,
                                           input logic ra, input logic rb, input logic ba, input logic bb);
        logic [15:0] c;
        c = '0;
        c[OPC_LSB +: 3]   = op;
        c[A_LSB +: 3]     = a;
        c[B_LSB +: 3]     = b;
        c[CIN_BIT]        = cin;
        c[SERIAL_IN_BIT]  = si;
        c[DIRECTION_BIT]  = dir;
        c[RED_OP_A_BIT]   = ra;
        c[RED_OP_B_BIT]   = rb;
        c[BYPASS_A_BIT]   = ba;
        c[BYPASS_B_BIT]   = bb;
        return c;
    endfunction

    // Random command avoiding shift/rotate dependence by forcing bypass on them
    function automatic logic [15:0] rand_cmd();
        logic [15:0] c;
        c = 16'($urandom);
        if (c[OPC_LSB +: 3] == OP_SHIFT || c[OPC_LSB +: 3] == OP_ROTATE) c[BYPASS_A_BIT] = 1'b1;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic [1:0] req_after);
        @(posedge clk); #1;
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        req = req_after;
    endtask

    // Single-port transaction with fixed four-cycle response check
    task automatic do_txn(input string name, input int port, input logic [15:0] cmd,
                          input logic [5:0] exp_data, input logic exp_err);
        logic [1:0] onehot;
        onehot = (port == 0) ? 2'b01 : 2'b10;
        @(posedge clk); #1;
        if (port == 0) cmd0 = cmd; else cmd1 = cmd;
        req = onehot;
        @(negedge clk);
        check({name, ".gnt"}, 32'(gnt), 32'(onehot));
        @(posedge clk); #1;
        req = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check({name, ".busy"}, 32'(busy), 32'd1);
            check({name, ".rv_early"}, 32'(rsp_valid), 32'd0);
            check({name, ".alsu_cmd"}, 32'(alsu_cmd), 32'(cmd));
        end
        @(negedge clk);
        check({name, ".rsp_valid"}, 32'(rsp_valid), 32'(onehot));
        check({name, ".rsp_data"}, 32'(rsp_data), 32'(exp_data));
        check({name, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({name, ".busy_end"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        string       name;
        int          port;
        logic [15:0] cmd;
        logic [5:0]  data;
        logic        err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt, last, rsp_at, rsp_port, port;
        logic [5:0]  rsp_d;
        logic        rsp_e;
        logic [15:0] cur_cmd, cmd_sel;
        logic [1:0]  exp_gnt, exp_rv, exp_fx_rv;

        rst  = 1'b1;
        req  = 2'b00;
        cmd0 = '0;
        cmd1 = '0;

        vecs[0] = '{"add",     0, mk_cmd(OP_ADD,   3'd3, 3'd2, 0, 0, 0, 0, 0, 0, 0), 6'd5,       1'b0};
        vecs[1] = '{"invalid", 1, mk_cmd(OP_ADD,   3'd1, 3'd1, 0, 0, 0, 1, 0, 0, 0), 6'd0,       1'b1};
        vecs[2] = '{"bypass",  0, mk_cmd(3'd7,     3'b110, 3'd0, 0, 0, 0, 0, 0, 1, 0), 6'b111110, 1'b1};
        vecs[3] = '{"or",      0, mk_cmd(OP_OR,    3'd1, 3'd0, 0, 0, 0, 0, 0, 0, 0), 6'd1,       1'b0};
        vecs[4] = '{"shift",   1, mk_cmd(OP_SHIFT, 3'd0, 3'd0, 0, 1, 1, 0, 0, 0, 0), 6'd3,       1'b0};

        // Reset state, including grant suppression while reset is held
        @(posedge clk); #1;
        req = 2'b11;
        @(negedge clk);
        check("rst.gnt", 32'(gnt), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_data", 32'(rsp_data), 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.alsu_cmd", 32'(alsu_cmd), 32'd0);
        @(posedge clk); #1;
        req = 2'b00;
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i].name, vecs[i].port, vecs[i].cmd, vecs[i].data, vecs[i].err);
        end

        // Reset while the op is in EXEC aborts it
        @(posedge clk); #1;
        cmd0 = mk_cmd(OP_ADD, 3'd3, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        req  = 2'b01;
        @(negedge clk);
        check("abort.gnt", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort.busy", 32'(busy), 32'd0);
            check("abort.gnt", 32'(gnt), 32'd0);
            check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        req = 2'b00;
        @(negedge clk);
        check("abort.rv_after", 32'(rsp_valid), 32'd0);
        do_txn("post_abort_mul", 0, mk_cmd(OP_MUL, 3'b111, 3'd3, 0, 0, 0, 0, 0, 0, 0), 6'b111101, 1'b0);

        // Continuous tie from reset: RR alternates, FIXED0 always port 0
        do_reset(2'b11);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            exp_gnt   = (k % 4 != 0) ? 2'b00 : (((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
            exp_rv    = (k >= 4 && k % 4 == 0) ? ((((k / 4) - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_fx_rv = (k >= 4 && k % 4 == 0) ? 2'b01 : 2'b00;
            check("tie.rr_gnt", 32'(gnt), 32'(exp_gnt));
            check("tie.rr_rv", 32'(rsp_valid), 32'(exp_rv));
            check("tie.fx_gnt", 32'(gnt_fx), 32'(exp_gnt != 2'b00 ? 2'b01 : 2'b00));
            check("tie.fx_rv", 32'(rsp_valid_fx), 32'(exp_fx_rv));
            @(posedge clk); #1;
        end

        // Random traffic against a cycle-level reference model
        do_reset(2'b00);
        busy_cnt = 0;
        last     = 1;
        rsp_at   = -1;
        rsp_port = 0;
        rsp_d    = '0;
        rsp_e    = 1'b0;
        cur_cmd  = '0;
        for (int c = 0; c < 400; c++) begin
            req  = 2'($urandom_range(0, 3));
            cmd0 = rand_cmd();
            cmd1 = rand_cmd();
            @(negedge clk);
            exp_gnt = 2'b00;
            port    = 0;
            if (busy_cnt == 0 && req != 2'b00) begin
                if (req == 2'b11) port = (last == 1) ? 0 : 1;
                else port = (req == 2'b01) ? 0 : 1;
                exp_gnt = (port == 0) ? 2'b01 : 2'b10;
            end
            exp_rv = (rsp_at == c) ? ((rsp_port == 0) ? 2'b01 : 2'b10) : 2'b00;
            check("rand.gnt", 32'(gnt), 32'(exp_gnt));
            check("rand.busy", 32'(busy), 32'(busy_cnt != 0));
            check("rand.rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (rsp_at == c) begin
                check("rand.rsp_data", 32'(rsp_data), 32'(rsp_d));
                check("rand.rsp_err", 32'(rsp_err), 32'(rsp_e));
            end
            if (busy_cnt != 0) check("rand.alsu_cmd", 32'(alsu_cmd), 32'(cur_cmd));
            if (exp_gnt != 2'b00) begin
                cmd_sel  = (port == 0) ? cmd0 : cmd1;
                busy_cnt = 3;
                last     = port;
                rsp_at   = c + 4;
                rsp_port = port;
                rsp_d    = alsu_f(cmd_sel, 6'h00);
                rsp_e    = ref_err(cmd_sel);
                cur_cmd  = cmd_sel;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
